// File: rtl/encode_pkg.sv
// encode_pkg: shared widths, output bounds and FSM states for the encoder MAC/requant slice
package encode_pkg;
  localparam int PROD_W = 70;
  localparam int ACC_W = 78;
  localparam int OUT_W = 32;
  localparam int SHIFT_W = 7;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUTPUT} state_t;
endpackage

// File: rtl/encode_round_sat.sv
// encode_round_sat: arithmetic right shift (rounded when ENCODE_REQUANT_ROUND_EN is defined) then clamp to OUT_W
module encode_round_sat
  import encode_pkg::*;
(
  input  logic signed [ACC_W-1:0]   acc,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat
);
  logic signed [ACC_W:0] ext, r;
`ifdef ENCODE_REQUANT_ROUND_EN
  logic [ACC_W:0] bias;
  // one extra bit of headroom so the half-LSB bias can never overflow
  assign bias = (shift == '0) ? '0 : {{ACC_W{1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
  assign ext = {acc[ACC_W-1], acc} + bias;
`else
  assign ext = {acc[ACC_W-1], acc};
`endif
  assign r = ext >>> shift;
  assign out_sat = (r > OUT_MAX) || (r < OUT_MIN);
  assign out_data = (r > OUT_MAX) ? OUT_MAX : (r < OUT_MIN) ? OUT_MIN : r[OUT_W-1:0];
endmodule

// File: rtl/encode_mac_requant.sv
// encode_mac_requant: accumulates signed products into a dot product and requantizes it (ENCODE_REQUANT_ROUND_EN enables rounding)
module encode_mac_requant
  import encode_pkg::*;
#(
  parameter int PROD_WIDTH  = PROD_W,
  parameter int ACC_WIDTH   = ACC_W,
  parameter int OUT_WIDTH   = OUT_W,
  parameter int SHIFT_WIDTH = SHIFT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [PROD_WIDTH-1:0]  in_data,
  input  logic                          in_last,
  input  logic        [SHIFT_WIDTH-1:0] in_shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_sat
);
  state_t state;
  logic signed [ACC_WIDTH-1:0] acc, term;
  logic [SHIFT_WIDTH-1:0] shift_r, shift_c;
  logic signed [OUT_WIDTH-1:0] rs_data;
  logic rs_sat, accept;
  assign in_ready = !reset && (state == IDLE || state == ACCUM);
  assign accept = in_valid && in_ready;
  assign term = {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
  assign shift_c = (in_shift > SHIFT_WIDTH'(ACC_WIDTH-1)) ? SHIFT_WIDTH'(ACC_WIDTH-1) : in_shift;
  encode_round_sat u_round_sat (
    .acc(acc),
    .shift(shift_r),
    .out_data(rs_data),
    .out_sat(rs_sat)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      shift_r <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc <= term;
          shift_r <= shift_c;
          state <= in_last ? ROUND : ACCUM;
        end
        ACCUM: if (accept) begin
          acc <= acc + term;
          if (in_last) state <= ROUND;
        end
        ROUND: begin
          out_data <= rs_data;
          out_sat <= rs_sat;
          out_valid <= 1'b1;
          state <= OUTPUT;
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
